// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and next-PC selection for the fetch
// stage. Three states: RUN (streaming), SQUASH (one bubble after a redirect or
// reset) and HALT (terminal until reset).
// Optional feature macro: PC_ALIGN_CHECK_EN. When it is defined, odd branch
// targets are forced even and a sticky misalign flag is raised.
// RESET_PC must be an even address.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        halt,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic [15:0] next_pc,
    output logic        valid,
    output logic        halted
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [15:0] targetPc;
    logic [15:0] selPc;

`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_q, misalign_d;

    // Odd redirect targets are rounded down to the halfword boundary.
    always_comb begin
        targetPc = {branch_target[15:1], 1'b0};
    end
`else
    // Redirect targets are used exactly as supplied.
    always_comb begin
        targetPc = branch_target;
    end
`endif

    // Sequential successor, wrapping silently past 16'hFFFE.
    always_comb begin
        pc_plus2 = pc_q + 16'd2;
    end

    // The 2:1 PC-select multiplexer: branch target when redirecting, else pc+2.
    always_comb begin
        selPc = branch_taken ? targetPc : pc_plus2;
    end

    // Next-state logic in priority order: HALT state, halt, branch, stall, increment.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        if (state_q == ST_HALT) begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
        end else if (halt) begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = ST_HALT;
        end else if (branch_taken) begin
            pc_d    = selPc;
            valid_d = 1'b0;
            state_d = ST_SQUASH;
`ifdef PC_ALIGN_CHECK_EN
            if (branch_target[0]) begin
                misalign_d = 1'b1;
            end
`endif
        end else if (stall) begin
            pc_d    = pc_q;
            valid_d = valid_q;
            state_d = state_q;
        end else begin
            pc_d    = selPc;
            valid_d = 1'b1;
            state_d = ST_RUN;
        end
    end

    // State and output registers; reset lands in SQUASH so the first edge is a squash exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SQUASH;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`endif

    assign pc      = pc_q;
    assign next_pc = pc_d;
    assign valid   = valid_q;
    assign halted  = halted_q;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset; SHALL be even.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port stall  input  1  hold PC; from hazard unit.
REQ-005 Port branch_taken  input  1  redirect request from EX stage.
REQ-006 Port branch_target  input  16  redirect address.
REQ-007 Port halt  input  1  HALT instruction decoded.
REQ-008 Port pc  output  16  current fetch address, registered.
REQ-009 Port pc_plus2  output  16  combinational pc + 2, modulo 2^16.
REQ-010 Port next_pc  output  16  address loaded at next edge; drives the 16-bit 2:1 PC-select multiplexer (inA = pc_plus2, inB = branch_target, S = branch_taken).
REQ-011 Port valid  output  1  registered; fetch slot holds a live instruction.
REQ-012 Port halted  output  1  registered; unit is in HALT.
REQ-013 Port misalign  output  1  registered; present only with PC_ALIGN_CHECK_EN.

Function
REQ-014 The unit SHALL implement three states: RUN, SQUASH and HALT.
REQ-015 Per-edge priority SHALL be: rst > state HALT > halt > branch_taken > stall > increment.
REQ-016 In RUN with no input asserted: pc <= pc_plus2; valid <= 1; state stays RUN.
REQ-017 In RUN or SQUASH with stall=1 and branch_taken=0: pc, valid and state SHALL hold.
REQ-018 With branch_taken=1 (not HALT): pc <= branch_target; valid <= 0; state <= SQUASH, regardless of stall.
REQ-019 In SQUASH with no input asserted: pc <= pc_plus2; valid <= 1; state <= RUN (exactly one bubble per redirect).
REQ-020 A branch_taken in SQUASH SHALL redirect again and remain in SQUASH.
REQ-021 halt=1 in RUN or SQUASH: pc holds; valid <= 0; halted <= 1; state <= HALT, even if branch_taken or stall is asserted.
REQ-022 HALT is terminal: pc, valid=0 and halted=1 SHALL hold until rst; all other inputs ignored.
REQ-023 next_pc SHALL equal the value pc takes at the next edge under REQ-015..022 (pc itself when holding).
REQ-024 Wrap-around: pc 16'hFFFE increments to 16'h0000 with no flag.
REQ-025 Fetch-to-valid latency after reset release SHALL be one cycle.

Reset
REQ-026 rst=1 SHALL asynchronously set pc=RESET_PC, valid=0, halted=0, misalign=0, state=SQUASH.
REQ-027 The first edge after rst deassertion SHALL behave as SQUASH exit (pc <= RESET_PC+2, valid <= 1) unless another input takes priority.
REQ-028 Reset asserted mid-operation, including in HALT, SHALL override all other activity in the same cycle.

Configuration
REQ-029 Macro PC_ALIGN_CHECK_EN defined: a redirect with branch_target[0]=1 loads {branch_target[15:1],1'b0}, sets misalign=1 (sticky until rst) and still enters SQUASH.
REQ-030 Macro PC_ALIGN_CHECK_EN undefined: branch_target is loaded unmodified, and the misalign port and its logic are absent.

Verification
REQ-031 Release rst with RESET_PC=16'h0000 and 3 idle cycles -> pc = 0000, 0002, 0004, 0006; valid 0,1,1,1.
REQ-032 pc=16'h0010, branch_taken=1 with target 16'h0100 for one cycle -> pc=0100 with valid=0, then pc=0102 with valid=1.
REQ-033 pc=16'h0020, stall=1 for 3 cycles -> pc stays 0020 and valid stays 1; then pc=0022; stall and branch_taken together -> branch wins.
REQ-034 pc=16'hFFFC with 2 idle cycles -> pc=FFFE, then 0000.
REQ-035 halt=1 with branch_taken=1 at pc=16'h0040 -> pc stays 0040, halted=1, valid=0 indefinitely; pulse rst -> pc=0000, halted=0.
REQ-036 With PC_ALIGN_CHECK_EN, branch_target=16'h0101 -> pc=0100 and misalign=1 until rst.
